// File: rtl/max7219_rx.sv
// Loopback receiver for the MAX7219 sck/din/load link: synchronizes the serial
// inputs, assembles 16-bit frames and keeps a shadow copy of the register file.
module max7219_rx #(
   parameter int DIGIT_NUM   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   sck,
   input  logic                   din,
   input  logic                   load,
   output logic                   frame_valid,
   output logic [3:0]             frame_addr,
   output logic [7:0]             frame_data,
   output logic                   frame_error,
   output logic [DIGIT_NUM*8-1:0] digit_data,
   output logic [7:0]             decode_mode,
   output logic [3:0]             intensity,
   output logic [2:0]             scan_limit,
   output logic                   shutdown_n,
   output logic                   display_test
);

   logic [SYNC_STAGES-1:0] sck_sync, din_sync, load_sync;
   logic                   sck_d, load_d;
   logic                   sck_rise_p0, load_rise_p0, din_p0;
   logic [15:0]            shreg, shreg_nxt;
   logic [4:0]             count, count_nxt;
   logic [3:0]             addr_nxt;
   logic [7:0]             data_nxt;

   // stage p0: synchronizers, delay flops and registered edge pulses
   always_ff @(posedge clock) begin
      if (!reset) begin
         sck_sync     <= '0;
         din_sync     <= '0;
         load_sync    <= '0;
         sck_d        <= 1'b0;
         load_d       <= 1'b0;
         sck_rise_p0  <= 1'b0;
         load_rise_p0 <= 1'b0;
         din_p0       <= 1'b0;
      end else begin
         sck_sync     <= {sck_sync[SYNC_STAGES-2:0], sck};
         din_sync     <= {din_sync[SYNC_STAGES-2:0], din};
         load_sync    <= {load_sync[SYNC_STAGES-2:0], load};
         sck_d        <= sck_sync[SYNC_STAGES-1];
         load_d       <= load_sync[SYNC_STAGES-1];
         sck_rise_p0  <= sck_sync[SYNC_STAGES-1] & ~sck_d;
         load_rise_p0 <= load_sync[SYNC_STAGES-1] & ~load_d;
         din_p0       <= din_sync[SYNC_STAGES-1];
      end
   end

   // A shift coinciding with a latch is applied first, so the latch sees it.
   always_comb begin
      shreg_nxt = shreg;
      count_nxt = count;
      if (sck_rise_p0) begin
         shreg_nxt = {shreg[14:0], din_p0};
         count_nxt = (count == 5'd17) ? 5'd17 : count + 5'd1;
      end
      addr_nxt = shreg_nxt[11:8];
      data_nxt = shreg_nxt[7:0];
   end

   // stage p1: shift register, frame latch and register file
   always_ff @(posedge clock) begin
      if (!reset) begin
         shreg        <= '0;
         count        <= '0;
         frame_valid  <= 1'b0;
         frame_error  <= 1'b0;
         frame_addr   <= '0;
         frame_data   <= '0;
         digit_data   <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         shreg       <= shreg_nxt;
         count       <= count_nxt;
         if (load_rise_p0) begin
            count <= '0;
            if (count_nxt >= 5'd16) begin
               frame_valid <= 1'b1;
               frame_addr  <= addr_nxt;
               frame_data  <= data_nxt;
               case (addr_nxt)
                  4'h9: decode_mode  <= data_nxt;
                  4'hA: intensity    <= data_nxt[3:0];
                  4'hB: scan_limit   <= data_nxt[2:0];
                  4'hC: shutdown_n   <= data_nxt[0];
                  4'hF: display_test <= data_nxt[0];
                  default: begin
                     for (int k = 0; k < DIGIT_NUM; k++)
                        if (addr_nxt == 4'(k + 1))
                           digit_data[8*k +: 8] <= data_nxt;
                  end
               endcase
            end else begin
               frame_error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx: bit-bangs frames on sck/din/load and checks
// the shadow registers, frame pulses and load-to-valid latency.
module tb_max7219_rx;

   localparam int DIGIT_NUM   = 8;
   localparam int SYNC_STAGES = 2;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   sck, din, load;
   logic                   frame_valid, frame_error, shutdown_n, display_test;
   logic [3:0]             frame_addr, intensity;
   logic [7:0]             frame_data, decode_mode;
   logic [2:0]             scan_limit;
   logic [DIGIT_NUM*8-1:0] digit_data;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int fv_base, fe_base;

   max7219_rx #(.DIGIT_NUM(DIGIT_NUM), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clock(clock), .reset(reset), .sck(sck), .din(din), .load(load),
      .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
      .frame_error(frame_error), .digit_data(digit_data), .decode_mode(decode_mode),
      .intensity(intensity), .scan_limit(scan_limit), .shutdown_n(shutdown_n),
      .display_test(display_test)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (frame_error === 1'b1) fe_cnt++;
      if (frame_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bits(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         din = val[i];
         tick(4);
         sck = 1'b1;
         tick(4);
         sck = 1'b0;
      end
      tick(2);
   endtask

   task automatic pulse_load();
      load = 1'b1;
      tick(4);
      load = 1'b0;
      tick(6);
   endtask

   initial begin
      reset = 1'b0; sck = 1'b0; din = 1'b0; load = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(2);
      check("rst_fv", frame_valid, 0);
      check("rst_fe", frame_error, 0);
      check("rst_addr", frame_addr, 0);
      check("rst_data", frame_data, 0);
      check("rst_digits", digit_data, 0);
      check("rst_shutdown", shutdown_n, 0);

      // 1: intensity frame
      fv_base = fv_cnt; fe_base = fe_cnt;
      send_bits(32'h0A05, 16); pulse_load();
      check("t1_fv_pulses", fv_cnt - fv_base, 1);
      check("t1_fe_pulses", fe_cnt - fe_base, 0);
      check("t1_addr", frame_addr, 4'hA);
      check("t1_data", frame_data, 8'h05);
      check("t1_intensity", intensity, 4'h5);
      check("t1_digits", digit_data, 0);
      check("t1_decode", decode_mode, 0);
      check("t1_scan", scan_limit, 0);
      check("t1_shutdown", shutdown_n, 0);
      check("t1_test", display_test, 0);

      // 2: digit 0, digit 7, shutdown
      fv_base = fv_cnt; fe_base = fe_cnt;
      send_bits(32'h0112, 16); pulse_load();
      send_bits(32'h0834, 16); pulse_load();
      send_bits(32'h0C01, 16); pulse_load();
      check("t2_fv_pulses", fv_cnt - fv_base, 3);
      check("t2_fe_pulses", fe_cnt - fe_base, 0);
      check("t2_digits", digit_data, 64'h3400_0000_0000_0012);
      check("t2_shutdown", shutdown_n, 1);

      // 3: short frame, then a good scan-limit frame
      fv_base = fv_cnt; fe_base = fe_cnt;
      send_bits(32'h0ABC, 12); pulse_load();
      check("t3_fe_pulses", fe_cnt - fe_base, 1);
      check("t3_fv_pulses", fv_cnt - fv_base, 0);
      check("t3_addr_held", frame_addr, 4'hC);
      check("t3_data_held", frame_data, 8'h01);
      check("t3_digits_held", digit_data, 64'h3400_0000_0000_0012);
      check("t3_intensity_held", intensity, 4'h5);
      send_bits(32'h0B07, 16); pulse_load();
      check("t3_scan", scan_limit, 3'd7);
      check("t3_fv_after", fv_cnt - fv_base, 1);

      // 4: 24-bit daisy-chain frame, last 16 bits apply
      send_bits(32'hFF0F01, 24); pulse_load();
      check("t4_test", display_test, 1);
      check("t4_addr", frame_addr, 4'hF);
      check("t4_data", frame_data, 8'h01);

      // 5: last sck rise and load rise together; latency check
      send_bits(32'h0903 >> 1, 15);
      din = 1'b1;
      tick(4);
      sck = 1'b1; load = 1'b1;
      @(posedge clock);
      for (int c = 1; c <= SYNC_STAGES + 1; c++) begin
         @(posedge clock); #1;
         check($sformatf("t5_fv_edge%0d", c), frame_valid, (c == SYNC_STAGES + 1) ? 1 : 0);
      end
      check("t5_decode", decode_mode, 8'h03);
      check("t5_addr", frame_addr, 4'h9);
      tick(2);
      sck = 1'b0; load = 1'b0;
      tick(6);

      // 6: reset mid-frame, then a fresh frame
      send_bits(32'hA5, 8);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(2);
      fv_base = fv_cnt; fe_base = fe_cnt;
      check("t6_rst_intensity", intensity, 0);
      check("t6_rst_digits", digit_data, 0);
      check("t6_rst_test", display_test, 0);
      send_bits(32'h0A0F, 16); pulse_load();
      check("t6_intensity", intensity, 4'hF);
      check("t6_fv_pulses", fv_cnt - fv_base, 1);
      check("t6_fe_pulses", fe_cnt - fe_base, 0);
      check("t6_decode", decode_mode, 0);

      check("never_both", both_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
